// File: rtl/store_capture_monitor.sv
// -----------------------------------------------------------------------------
// store_capture_monitor
//
// Listens to the CPU store interface and records every store into a
// show-ahead FIFO that a host/debug reader drains with a pop handshake.
// A programmable address/data pair is also watched and latched as a sticky
// "match" flag, typically used to spot the end-of-program store.
//
// Optional feature (macro STORE_CAPTURE_TIMESTAMP_EN):
//   Adds a 16-bit free-running cycle counter. Each entry also records the
//   counter value at its push edge, and the head timestamp appears on rd_time.
//
// Parameters:
//   DEPTH       FIFO entries (power of two, >= 2)
//   MATCH_ADDR  store address that raises match
//   MATCH_DATA  store data that raises match
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   MemWrite   CPU store strobe (one store per cycle while high)
//   DataAdr    CPU store address
//   WriteData  CPU store data
//   pop        reader consumes the head entry
//   clr_match  clears the match flag (a same-cycle match wins)
//   rd_valid   FIFO not empty
//   rd_addr    head entry address (0 when empty)
//   rd_data    head entry data (0 when empty)
//   count      number of stored entries
//   full       count == DEPTH
//   overflow   sticky: a store was dropped because the FIFO was full
//   match      sticky: the matching store was observed
//   rd_time    head entry timestamp, 0 when empty (timestamp build only)
// -----------------------------------------------------------------------------
module store_capture_monitor #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] MATCH_ADDR = 32'd200,
    parameter logic [31:0] MATCH_DATA = 32'd1,
    localparam int         AW         = $clog2(DEPTH),
    localparam int         CW         = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [31:0]   DataAdr,
    input  logic [31:0]   WriteData,
    input  logic          pop,
    input  logic          clr_match,
    output logic          rd_valid,
    output logic [31:0]   rd_addr,
    output logic [31:0]   rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          overflow,
    output logic          match
`ifdef STORE_CAPTURE_TIMESTAMP_EN
    ,
    output logic [15:0]   rd_time
`endif
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
`ifdef STORE_CAPTURE_TIMESTAMP_EN
        logic [15:0] ts;
`endif
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    entry_t        wr_entry;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          empty;
    logic          is_full;
    logic          do_push;
    logic          do_pop;
    logic          drop;
    logic          hit;

`ifdef STORE_CAPTURE_TIMESTAMP_EN
    logic [15:0]   ts_cnt;
`endif

    assign empty   = (cnt == '0);
    assign is_full = (cnt == DEPTH_C);

    // A pop on an empty FIFO is ignored. When full, a same-cycle pop frees the
    // slot so the push still goes in; otherwise a push while full is dropped.
    assign do_pop  = pop & ~empty;
    assign do_push = MemWrite & (~is_full | do_pop);
    assign drop    = MemWrite & is_full & ~do_pop;

    // Match compare ignores FIFO state so a dropped store still flags.
    assign hit     = MemWrite & (DataAdr == MATCH_ADDR) & (WriteData == MATCH_DATA);

    always_comb begin
        wr_entry      = '0;
        wr_entry.addr = DataAdr;
        wr_entry.data = WriteData;
`ifdef STORE_CAPTURE_TIMESTAMP_EN
        wr_entry.ts   = ts_cnt;
`endif
    end

    // Control state: pointers, occupancy and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            match    <= 1'b0;
`ifdef STORE_CAPTURE_TIMESTAMP_EN
            ts_cnt   <= '0;
`endif
        end else begin
            // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);

            // Occupancy follows the push/pop decisions; with both it holds.
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase

            if (drop) overflow <= 1'b1;

            // Set has priority over clear.
            if (hit)            match <= 1'b1;
            else if (clr_match) match <= 1'b0;

`ifdef STORE_CAPTURE_TIMESTAMP_EN
            ts_cnt <= ts_cnt + 16'd1;
`endif
        end
    end

    // Storage array has no reset: after reset the pointers and count make
    // any stale contents unreachable, and outputs are forced to 0 when empty.
    always_ff @(posedge clk) begin
        if (do_push && reset) mem[wr_ptr] <= wr_entry;
    end

    assign head = mem[rd_ptr];

    // Outputs are derived only from registered state, never from the store
    // inputs, so there is no input-to-output combinational path.
    always_comb begin
        rd_valid = ~empty;
        rd_addr  = empty ? 32'd0 : head.addr;
        rd_data  = empty ? 32'd0 : head.data;
        count    = cnt;
        full     = is_full;
    end

`ifdef STORE_CAPTURE_TIMESTAMP_EN
    assign rd_time = empty ? 16'd0 : head.ts;
`endif

endmodule
